// File: rtl/pu_pkg.sv
// Shared definitions for the processing-unit register/flag slice: widths,
// compare-op flag indices, opcodes and the register-block state encoding.
package pu_pkg;

    localparam int OPTION_REG_WIDTH_DEFAULT    = 64;
    localparam int OPTION_CMP_OP_WIDTH_DEFAULT = 4;
    localparam int REG_SEL_WIDTH               = 5;
    localparam int NUM_REGS                    = 1 << REG_SEL_WIDTH;

    // Compare-op codes: index of the flag result a unit selects.
    localparam logic [3:0] FLAG_INDEX_EQ  = 4'd0;
    localparam logic [3:0] FLAG_INDEX_NE  = 4'd1;
    localparam logic [3:0] FLAG_INDEX_LT  = 4'd2;
    localparam logic [3:0] FLAG_INDEX_GE  = 4'd3;
    localparam logic [3:0] FLAG_INDEX_LTU = 4'd4;
    localparam logic [3:0] FLAG_INDEX_GEU = 4'd5;
    localparam logic [3:0] FLAG_INDEX_GT  = 4'd6;
    localparam logic [3:0] FLAG_INDEX_LE  = 4'd7;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_AND  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h04;
    localparam logic [5:0] OP_XOR  = 6'h05;
    localparam logic [5:0] OP_CMP  = 6'h06;
    localparam logic [5:0] OP_LOAD = 6'h07;

    typedef enum logic {
        REGS_INIT = 1'b0,
        REGS_RUN  = 1'b1
    } regs_state_e;

endpackage

// File: rtl/pu_regs_flags_if.sv
// Register/flag bus between processing units (master) and the register block (slave).
// Reads are combinational; writes and strobes are single-cycle, no backpressure.
interface pu_regs_flags_if
    import pu_pkg::*;
#(
    parameter int REG_W = OPTION_REG_WIDTH_DEFAULT,
    parameter int CMP_W = OPTION_CMP_OP_WIDTH_DEFAULT
) ();

    logic [REG_SEL_WIDTH-1:0] i_sela;
    logic [REG_SEL_WIDTH-1:0] i_selb;
    logic [REG_W-1:0]         o_ina;
    logic [REG_W-1:0]         o_inb;
    logic [REG_SEL_WIDTH-1:0] i_write_reg;
    logic [REG_W-1:0]         i_write_data;
    logic                     i_write_en;
    logic                     i_flag_cmp;
    logic                     i_write_flag;
    logic                     o_flag;
    logic [CMP_W-1:0]         i_cmp_op_data;
    logic                     i_cmp_op_load;
    logic [CMP_W-1:0]         o_cmp_op;
    logic                     o_ready;

    modport master (
        output i_sela, i_selb, i_write_reg, i_write_data, i_write_en,
               i_flag_cmp, i_write_flag, i_cmp_op_data, i_cmp_op_load,
        input  o_ina, o_inb, o_flag, o_cmp_op, o_ready
    );

    modport slave (
        input  i_sela, i_selb, i_write_reg, i_write_data, i_write_en,
               i_flag_cmp, i_write_flag, i_cmp_op_data, i_cmp_op_load,
        output o_ina, o_inb, o_flag, o_cmp_op, o_ready
    );

endinterface

// File: rtl/pu_regfile_array.sv
// Unreset 32-entry register storage: one write port, two async read ports, r0 reads 0.
// Zero read latency; PU_REGS_BYPASS_EN forwards same-cycle write data to matching reads.
module pu_regfile_array
    import pu_pkg::*;
#(
    parameter int WIDTH = OPTION_REG_WIDTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [REG_SEL_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [REG_SEL_WIDTH-1:0] raddr_a,
    input  logic [REG_SEL_WIDTH-1:0] raddr_b,
    output logic [WIDTH-1:0]         rdata_a,
    output logic [WIDTH-1:0]         rdata_b
);

    logic [WIDTH-1:0] mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef PU_REGS_BYPASS_EN
    logic fwd_a;
    logic fwd_b;

    assign fwd_a = we && (waddr != '0) && (raddr_a == waddr);
    assign fwd_b = we && (waddr != '0) && (raddr_b == waddr);

    assign rdata_a = (raddr_a == '0) ? '0 : (fwd_a ? wdata : mem[raddr_a]);
    assign rdata_b = (raddr_b == '0) ? '0 : (fwd_b ? wdata : mem[raddr_b]);
`else
    assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];
`endif

endmodule

// File: rtl/pu_regs_flags.sv
// Register/flag responder: zero-clears r1..r31 after reset, then serves reads and accepts writes.
// Reads zero-latency, writes/strobes take effect next edge; no backpressure (optional PU_REGS_BYPASS_EN).
module pu_regs_flags
    import pu_pkg::*;
#(
    parameter int OPTION_REG_WIDTH    = OPTION_REG_WIDTH_DEFAULT,
    parameter int OPTION_CMP_OP_WIDTH = OPTION_CMP_OP_WIDTH_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst,
    pu_regs_flags_if.slave  bus
);

    regs_state_e                state;
    logic [REG_SEL_WIDTH-1:0]   init_cnt;
    logic                       ready;
    logic                       flag;
    logic [OPTION_CMP_OP_WIDTH-1:0] cmp_op;

    logic                       arr_we;
    logic [REG_SEL_WIDTH-1:0]   arr_waddr;
    logic [OPTION_REG_WIDTH-1:0] arr_wdata;
    logic [OPTION_REG_WIDTH-1:0] rd_a;
    logic [OPTION_REG_WIDTH-1:0] rd_b;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= REGS_INIT;
            init_cnt <= 5'd1;
            ready    <= 1'b0;
            flag     <= 1'b0;
            cmp_op   <= '0;
        end else begin
            case (state)
                REGS_INIT: begin
                    // Counter stops at 31 rather than wrapping; RUN is terminal.
                    if (init_cnt == 5'd31) begin
                        state <= REGS_RUN;
                        ready <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 5'd1;
                    end
                end
                REGS_RUN: begin
                    if (bus.i_write_flag) begin
                        flag <= bus.i_flag_cmp;
                    end
                    if (bus.i_cmp_op_load) begin
                        cmp_op <= bus.i_cmp_op_data;
                    end
                end
                default: begin
                    state <= REGS_INIT;
                end
            endcase
        end
    end

    // During INIT the sequencer owns the write port; user writes to r0 are dropped in RUN.
    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = bus.i_write_reg;
        arr_wdata = bus.i_write_data;
        if (state == REGS_INIT) begin
            arr_we    = 1'b1;
            arr_waddr = init_cnt;
            arr_wdata = '0;
        end else if (bus.i_write_en && (bus.i_write_reg != '0)) begin
            arr_we = 1'b1;
        end
    end

    pu_regfile_array #(
        .WIDTH (OPTION_REG_WIDTH)
    ) u_array (
        .clk     (i_clk),
        .we      (arr_we),
        .waddr   (arr_waddr),
        .wdata   (arr_wdata),
        .raddr_a (bus.i_sela),
        .raddr_b (bus.i_selb),
        .rdata_a (rd_a),
        .rdata_b (rd_b)
    );

    assign bus.o_ina    = (state == REGS_RUN) ? rd_a : '0;
    assign bus.o_inb    = (state == REGS_RUN) ? rd_b : '0;
    assign bus.o_flag   = flag;
    assign bus.o_cmp_op = cmp_op;
    assign bus.o_ready  = ready;

endmodule

// File: doc/pu_regs_flags.md
Name: pu_regs_flags

Overview:
- Responder end of the processing-unit register/flag interface.
- Holds the general-purpose register file and serves two combinational read ports, selected by the active unit's select outputs.
- Accepts one register write and one compare-flag write per cycle from whichever unit holds the unique ack.
- Holds the compare-operation code that units use to select their flag result.
- Register storage is not reset (RAM-friendly); after reset, an init sequencer zero-clears it before the block signals ready.

Parameters:
- OPTION_REG_WIDTH, 64, register data width in bits.
- OPTION_CMP_OP_WIDTH, 4, width of the compare-operation code.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_sela  input  5  read port A register select.
- i_selb  input  5  read port B register select.
- o_ina  output  OPTION_REG_WIDTH  read port A data.
- o_inb  output  OPTION_REG_WIDTH  read port B data.
- i_write_reg  input  5  destination register of write.
- i_write_data  input  OPTION_REG_WIDTH  write data.
- i_write_en  input  1  write strobe, sampled on rising edge.
- i_flag_cmp  input  1  new compare flag value.
- i_write_flag  input  1  flag write strobe, sampled on rising edge.
- o_flag  output  1  current compare flag.
- i_cmp_op_data  input  OPTION_CMP_OP_WIDTH  compare-op code from the Control Unit.
- i_cmp_op_load  input  1  load strobe for the compare-op code.
- o_cmp_op  output  OPTION_CMP_OP_WIDTH  current compare-op code, fed to processing units.
- o_ready  output  1  high once init is complete; writes are honoured only while high.

Behaviour:
- Reset values:
  - Async reset forces state INIT, init counter = 1, o_ready = 0, o_flag = 0, o_cmp_op = 0.
  - Array contents are undefined during reset.
- State INIT:
  - Each rising edge writes 0 to reg[counter], then counter increments.
  - The edge that writes r31 moves the state to RUN and sets o_ready = 1.
  - o_ready therefore rises exactly 31 edges after reset deasserts.
  - All write, flag and cmp_op strobes are ignored.
  - o_ina and o_inb are forced to 0.
- State RUN:
  - Register write: if i_write_en and i_write_reg != 0, reg[i_write_reg] <= i_write_data on the rising edge.
  - Writes to r0 are dropped.
  - If i_write_flag, o_flag <= i_flag_cmp.
  - If i_cmp_op_load, o_cmp_op <= i_cmp_op_data.
  - The three updates are independent and may all occur in the same cycle.
- Reads:
  - Combinational, zero latency.
  - Select 0 always returns 0.
  - A write and a read of the same register in the same cycle returns the OLD value (see Optional Feature).
  - i_sela == i_selb is legal; both ports return the same value.
- RUN is terminal; the only exit is reset.
- Reset asserted mid-RUN or mid-INIT returns immediately to INIT and re-clears from r1. No partial state survives except the array, which is re-zeroed.
- Counter is 5 bits and never wraps; the transition out of INIT happens at 31.

Optional Feature:
- Macro: PU_REGS_BYPASS_EN.
- Defined: in RUN, if i_write_en and i_write_reg != 0 and a read select equals i_write_reg, that port returns i_write_data in the same cycle (write-to-read forwarding).
- Undefined: no forwarding; reads return stored contents and the written value is visible from the next cycle.
- r0 and INIT behaviour are identical in both builds.

Decomposition:
- Shared package pu_pkg holds:
  - OPTION_REG_WIDTH default.
  - Register-select width (5).
  - OPTION_CMP_OP_WIDTH default.
  - FLAG_INDEX_* compare-op constants.
  - Opcode constants.
  - Regs state encoding (INIT, RUN).
- Natural sub-module: pu_regfile_array, containing the storage with one write port, two async read ports and r0 masking, plus the optional bypass.
- Top level keeps the init FSM, flag flop and cmp_op flop.

Test Plan:
- Init sweep: release reset, write r5 = 0x1234 at edge 3 -> write ignored; o_ready low for 31 edges, high after; reading r1..r31 returns 0.
- RUN write and read: write r7 = 0xDEADBEEF_00000001 -> next cycle o_ina with sela = 7 returns that value; o_inb with selb = 7 matches.
- r0 protection: write r0 = 0xFFFF... -> reading r0 returns 0 on both ports.
- Same-cycle conflict: r3 holds 0x10; write r3 = 0x20 while sela = 3 -> o_ina = 0x10 without PU_REGS_BYPASS_EN, 0x20 with it; 0x20 on the next cycle in both builds.
- Flag and cmp_op: i_write_flag = 1, i_flag_cmp = 1 and i_cmp_op_load = 1, data = 10 in the same cycle -> o_flag = 1 and o_cmp_op = 10 next cycle; with strobes low, values are held.
- Reset mid-RUN: after writing r9 = 0x55, pulse i_rst asynchronously between edges -> o_ready, o_flag and o_cmp_op drop immediately; r9 reads 0 after the 31-edge re-init.
